// File: rtl/btle_adv_pkg.sv
// Shared constants for the BLE advertising event sequencer: state codes,
// advertising channel numbers and the fixed advertising link-layer values.
package btle_adv_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_WAIT_TX  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_INTERVAL = 3'd5;

  localparam int ADV_CH37 = 37;
  localparam int ADV_CH38 = 38;
  localparam int ADV_CH39 = 39;

  localparam logic [7:0]  ADV_PREAMBLE               = 8'hAA;
  localparam logic [31:0] ADV_ACCESS_ADDRESS_DEFAULT = 32'h8E89BED6;
  localparam logic [23:0] ADV_CRC_INIT_DEFAULT       = 24'h555555;

  // Returns {found, index} of the lowest set bit of map at or above 'from'.
  function automatic logic [2:0] find_set_bit(input logic [2:0] map, input logic [1:0] from);
    logic [2:0] result;
    result = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (map[i] && (2'(i) >= from)) begin
        result = {1'b1, 2'(i)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/btle_down_counter.sv
// Loadable down counter that saturates at zero; one instance serves the
// inter-packet gap, the advertising interval and the transmit watchdog.
module btle_down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/btle_adv_event_ctrl.sv
// Advertising event sequencer: walks the enabled channels 37/38/39, drives
// btle_tx loads and tx_start, and times gaps, intervals and a TX watchdog.
module btle_adv_event_ctrl
  import btle_adv_pkg::*;
#(
  parameter int                              CRC_STATE_BIT_WIDTH      = 24,
  parameter int                              CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int                              TIMER_BIT_WIDTH          = 32,
  parameter logic [31:0]                     ADV_ACCESS_ADDRESS       = ADV_ACCESS_ADDRESS_DEFAULT,
  parameter logic [CRC_STATE_BIT_WIDTH-1:0]  ADV_CRC_INIT             = ADV_CRC_INIT_DEFAULT,
  parameter int                              TX_TIMEOUT_CYCLES        = 8192
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  logic [2:0]                          i_chan_map,
  input  logic [TIMER_BIT_WIDTH-1:0]          i_gap_cycles,
  input  logic [TIMER_BIT_WIDTH-1:0]          i_interval_cycles,
  input  logic                                i_iq_valid_last,
  output logic [7:0]                          o_preamble,
  output logic [31:0]                         o_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      o_crc_state_init_bit,
  output logic                                o_crc_state_init_bit_load,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] o_channel_number,
  output logic                                o_channel_number_load,
  output logic                                o_tx_start,
  output logic                                o_busy,
  output logic                                o_event_done,
  output logic                                o_tx_timeout,
  output logic [15:0]                         o_event_count
);

  logic [2:0]                          r_state;
  logic [2:0]                          r_map;
  logic [1:0]                          r_idx;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] r_chan;
  logic                                r_load;
  logic                                r_tx_start;
  logic                                r_busy;
  logic                                r_done;
  logic                                r_timeout;
  logic [15:0]                         r_event_count;

  logic [2:0]                 w_state_nxt;
  logic [2:0]                 w_map_nxt;
  logic [1:0]                 w_idx_nxt;
  logic [2:0]                 w_first;
  logic [2:0]                 w_next;
  logic                       w_tmr_load;
  logic [TIMER_BIT_WIDTH-1:0] w_tmr_value;
  logic                       w_tmr_dec;
  logic                       w_tmr_zero;
  logic                       w_load_pulse;
  logic                       w_tx_start;
  logic                       w_done;
  logic                       w_timeout;

  assign w_first = find_set_bit(i_chan_map, 2'd0);
  assign w_next  = find_set_bit(r_map, r_idx + 2'd1);

  btle_down_counter #(
    .WIDTH(TIMER_BIT_WIDTH)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_tmr_load),
    .i_load_value(w_tmr_value),
    .i_dec       (w_tmr_dec),
    .o_zero      (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_map_nxt    = r_map;
    w_idx_nxt    = r_idx;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    w_tmr_dec    = 1'b0;
    w_load_pulse = 1'b0;
    w_tx_start   = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && w_first[2]) begin
          w_map_nxt   = i_chan_map;
          w_idx_nxt   = w_first[1:0];
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load_pulse = 1'b1;
        w_state_nxt  = ST_START;
      end
      ST_START: begin
        w_tx_start  = 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_value = TIMER_BIT_WIDTH'(TX_TIMEOUT_CYCLES);
        w_state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // End of packet beats watchdog expiry; disabling with channels still
        // pending abandons the event without reporting it as done.
        if (i_iq_valid_last) begin
          if (w_next[2]) begin
            if (i_enable) begin
              w_idx_nxt   = w_next[1:0];
              w_tmr_load  = 1'b1;
              w_tmr_value = i_gap_cycles;
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_done      = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = i_interval_cycles;
            w_state_nxt = i_enable ? ST_INTERVAL : ST_IDLE;
          end
        end else if (w_tmr_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_INTERVAL: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmr_zero) begin
          if (w_first[2]) begin
            w_map_nxt   = i_chan_map;
            w_idx_nxt   = w_first[1:0];
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_map         <= 3'b000;
      r_idx         <= 2'd0;
      r_chan        <= CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH37);
      r_load        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_event_count <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_map      <= w_map_nxt;
      r_idx      <= w_idx_nxt;
      r_load     <= w_load_pulse;
      r_tx_start <= w_tx_start;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done;
      r_timeout  <= w_timeout;
      if (w_load_pulse) begin
        r_chan <= CHANNEL_NUMBER_BIT_WIDTH'(ADV_CH37 + int'(r_idx));
      end
      if (w_done) begin
        r_event_count <= r_event_count + 16'd1;
      end
    end
  end

  assign o_preamble                = ADV_PREAMBLE;
  assign o_access_address          = ADV_ACCESS_ADDRESS;
  assign o_crc_state_init_bit      = ADV_CRC_INIT;
  assign o_crc_state_init_bit_load = r_load;
  assign o_channel_number          = r_chan;
  assign o_channel_number_load     = r_load;
  assign o_tx_start                = r_tx_start;
  assign o_busy                    = r_busy;
  assign o_event_done              = r_done;
  assign o_tx_timeout              = r_timeout;
  assign o_event_count             = r_event_count;

endmodule

// File: tb/tb_btle_adv_event_ctrl.sv
// Directed bench for btle_adv_event_ctrl with a simple btle_tx model that
// answers each tx_start with iq_valid_last a fixed number of cycles later.
module tb_btle_adv_event_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  chanMap = 3'b000;
  logic [31:0] gapCycles = 32'd20;
  logic [31:0] intervalCycles = 32'd100;
  logic        iqValidLast = 1'b0;
  logic [7:0]  preamble;
  logic [31:0] accessAddress;
  logic [23:0] crcInit;
  logic        crcLoad;
  logic [5:0]  channelNumber;
  logic        chanLoad;
  logic        txStart;
  logic        busy;
  logic        eventDone;
  logic        txTimeout;
  logic [15:0] eventCount;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int modelCnt = 0;
  bit modelOn = 1'b1;
  int chanLog[$];
  int loadLog[$];
  int crcLoadLog[$];
  int txStartLog[$];
  int doneLog[$];
  int timeoutLog[$];

  btle_adv_event_ctrl dut (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_enable                 (enable),
    .i_chan_map               (chanMap),
    .i_gap_cycles             (gapCycles),
    .i_interval_cycles        (intervalCycles),
    .i_iq_valid_last          (iqValidLast),
    .o_preamble               (preamble),
    .o_access_address         (accessAddress),
    .o_crc_state_init_bit     (crcInit),
    .o_crc_state_init_bit_load(crcLoad),
    .o_channel_number         (channelNumber),
    .o_channel_number_load    (chanLoad),
    .o_tx_start               (txStart),
    .o_busy                   (busy),
    .o_event_done             (eventDone),
    .o_tx_timeout             (txTimeout),
    .o_event_count            (eventCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // btle_tx stand-in: iq_valid_last is sampled 50 edges after tx_start's edge.
  always @(negedge clk) begin
    iqValidLast = 1'b0;
    if (txStart && modelOn) begin
      modelCnt = 49;
    end else if (modelCnt > 0) begin
      modelCnt = modelCnt - 1;
      if (modelCnt == 0) iqValidLast = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chanLoad) begin
      chanLog.push_back(int'(channelNumber));
      loadLog.push_back(cyc);
    end
    if (crcLoad) crcLoadLog.push_back(cyc);
    if (txStart) txStartLog.push_back(cyc);
    if (eventDone) doneLog.push_back(cyc);
    if (txTimeout) timeoutLog.push_back(cyc);
  end

  task automatic applyStimulus(input logic en, input logic [2:0] map);
    enable  = en;
    chanMap = map;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int enCyc;
    int busyLowCyc;
    int nChan;
    bit busySeen;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_channel", 32'(channelNumber), 32'd37);
    checkOutput("reset_tx_start", 32'(txStart), 32'd0);
    checkOutput("reset_loads", 32'({crcLoad, chanLoad}), 32'd0);
    checkOutput("reset_pulses", 32'({eventDone, txTimeout}), 32'd0);
    checkOutput("reset_event_count", 32'(eventCount), 32'd0);
    checkOutput("preamble", 32'(preamble), 32'hAA);
    checkOutput("access_address", accessAddress, 32'h8E89BED6);
    checkOutput("crc_init", 32'(crcInit), 32'h555555);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full channel map, gap 20, interval 100");
    enCyc = cyc;
    applyStimulus(1'b1, 3'b111);
    for (int i = 0; i < 400 && doneLog.size() < 1; i++) @(negedge clk);
    checkOutput("event1_done_seen", 32'(doneLog.size()), 32'd1);
    checkOutput("event1_count", 32'(eventCount), 32'd1);
    checkOutput("first_load_latency", 32'(loadLog[0] - enCyc), 32'd2);
    checkOutput("first_crc_load_latency", 32'(crcLoadLog[0] - enCyc), 32'd2);
    checkOutput("first_tx_start_latency", 32'(txStartLog[0] - enCyc), 32'd3);
    checkOutput("chan0", 32'(chanLog[0]), 32'd37);
    checkOutput("chan1", 32'(chanLog[1]), 32'd38);
    checkOutput("chan2", 32'(chanLog[2]), 32'd39);
    checkOutput("tx_spacing_37_38", 32'(txStartLog[1] - txStartLog[0]), 32'd73);
    checkOutput("tx_spacing_38_39", 32'(txStartLog[2] - txStartLog[1]), 32'd73);
    checkOutput("done_after_last_iq", 32'(doneLog[0] - txStartLog[2]), 32'd50);

    for (int i = 0; i < 300 && txStartLog.size() < 4; i++) @(negedge clk);
    checkOutput("event2_start_seen", 32'(txStartLog.size()), 32'd4);
    checkOutput("interval_spacing", 32'(txStartLog[3] - doneLog[0]), 32'd103);
    checkOutput("event2_chan", 32'(chanLog[3]), 32'd37);

    $display("[TB] drop enable during ch37 packet");
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 3'b111);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    busyLowCyc = cyc;
    checkOutput("abort_busy_low_at_iq", 32'(busyLowCyc - txStartLog[3]), 32'd50);
    repeat (30) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneLog.size()), 32'd1);
    checkOutput("abort_no_ch38", 32'(txStartLog.size()), 32'd4);
    checkOutput("abort_event_count", 32'(eventCount), 32'd1);

    $display("[TB] channel map 101");
    applyStimulus(1'b1, 3'b101);
    for (int i = 0; i < 400 && doneLog.size() < 2; i++) @(negedge clk);
    applyStimulus(1'b0, 3'b101);
    checkOutput("map101_done_seen", 32'(doneLog.size()), 32'd2);
    checkOutput("map101_chan_a", 32'(chanLog[4]), 32'd37);
    checkOutput("map101_chan_b", 32'(chanLog[5]), 32'd39);
    checkOutput("map101_spacing", 32'(txStartLog[5] - txStartLog[4]), 32'd73);
    checkOutput("map101_event_count", 32'(eventCount), 32'd2);
    repeat (3) @(negedge clk);
    checkOutput("interval_abort_busy", 32'(busy), 32'd0);

    $display("[TB] empty channel map with enable high");
    applyStimulus(1'b1, 3'b000);
    busySeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busySeen = 1'b1;
    end
    checkOutput("empty_map_busy", 32'(busySeen), 32'd0);
    checkOutput("empty_map_no_tx", 32'(txStartLog.size()), 32'd6);

    $display("[TB] watchdog expiry");
    modelOn = 1'b0;
    applyStimulus(1'b1, 3'b001);
    for (int i = 0; i < 9000 && timeoutLog.size() < 1; i++) @(negedge clk);
    applyStimulus(1'b0, 3'b001);
    checkOutput("timeout_seen", 32'(timeoutLog.size()), 32'd1);
    checkOutput("timeout_latency", 32'(timeoutLog[0] - txStartLog[6]), 32'd8193);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_no_done", 32'(doneLog.size()), 32'd2);
    modelOn = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset during gap");
    applyStimulus(1'b1, 3'b111);
    for (int i = 0; i < 400 && txStartLog.size() < 9; i++) @(negedge clk);
    repeat (55) @(negedge clk);
    checkOutput("pre_reset_channel", 32'(channelNumber), 32'd38);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("gap_reset_busy", 32'(busy), 32'd0);
    checkOutput("gap_reset_channel", 32'(channelNumber), 32'd37);
    checkOutput("gap_reset_event_count", 32'(eventCount), 32'd0);
    checkOutput("gap_reset_pulses", 32'({txStart, chanLoad, eventDone, txTimeout}), 32'd0);
    nChan = chanLog.size();
    rst = 1'b0;
    for (int i = 0; i < 50 && chanLog.size() <= nChan; i++) @(negedge clk);
    checkOutput("restart_seen", 32'(chanLog.size() - nChan), 32'd1);
    checkOutput("restart_chan", 32'(chanLog[nChan]), 32'd37);
    applyStimulus(1'b0, 3'b000);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
